shared_net_arbiter: RTL

- Round-robin arbiter granting exclusive drive rights on one shared multi-driven (tri/triand) net to up to NREQ requesters.
- Emits one-hot registered drive enables, bounds ownership with a hold limit, and inserts turnaround cycles so two drivers never overlap.
- Sits beside shared-net modules; each requester gates its continuous assign with its drv_en bit.

---
 rtl/shared_net_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/shared_net_arbiter.sv
// Round-robin owner arbiter for one shared tri/triand net: one-hot registered drive enables,
// bounded hold time and turnaround gaps. Define SNA_CONTENTION_CHECK_EN for the bus_mon X/Z monitor.
//
// state  | meaning
// S_IDLE | bus released, arbitrating pending requests from the round-robin pointer
// S_OWN  | one requester owns the net and drives it
// S_TURN | all drivers released for TURN cycles before the next grant
module shared_net_arbiter #(
   parameter int NREQ     = 4,
   parameter int DW       = 8,
   parameter int MAX_HOLD = 4,
   parameter int TURN     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0]       done,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       drv_en,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                  bus_busy,
   output logic                  timeout
`ifdef SNA_CONTENTION_CHECK_EN
   ,
   input  logic [DW-1:0]         bus_mon,
   output logic                  bus_err
`endif
);

   localparam int IW = $clog2(NREQ);
   localparam int HW = (MAX_HOLD < 3) ? 2 : $clog2(MAX_HOLD + 1);
   localparam int TW = (TURN > 1) ? $clog2(TURN) : 1;

   typedef enum logic [1:0] {S_IDLE, S_OWN, S_TURN} state_t;

   state_t          state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [TW-1:0]   turn_q, turn_d;
   logic            timeout_q, timeout_d;
   logic            busy_q;

   logic            found;
   logic [IW-1:0]   win;
   logic [IW:0]     idx;
   logic            rel_done;
   logic            rel_limit;

   // First pending request at or after the pointer, wrapping modulo NREQ.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = {1'b0, ptr_q} + (IW+1)'(i);
         if (idx >= (IW+1)'(NREQ)) idx = idx - (IW+1)'(NREQ);
         if (!found && req[idx[IW-1:0]]) begin
            found = 1'b1;
            win   = idx[IW-1:0];
         end
      end
   end

   assign rel_done  = done[owner_q] | ~req[owner_q];
   assign rel_limit = (MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD));

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      turn_d    = turn_q;
      timeout_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               gnt_d      = '0;
               gnt_d[win] = 1'b1;
               owner_d    = win;
               hold_d     = HW'(1);
               state_d    = S_OWN;
            end
         end
         S_OWN: begin
            if (rel_done || rel_limit) begin
               gnt_d     = '0;
               ptr_d     = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
               hold_d    = '0;
               turn_d    = TW'(TURN - 1);
               // A voluntary release wins over a coincident hold-limit expiry.
               timeout_d = rel_limit && !rel_done;
               state_d   = S_TURN;
            end else if (hold_q != '1) begin
               hold_d = hold_q + 1'b1;
            end
         end
         S_TURN: begin
            if (turn_q == '0) state_d = S_IDLE;
            else              turn_d  = turn_q - 1'b1;
         end
         default: begin
            gnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         gnt_q     <= '0;
         owner_q   <= '0;
         ptr_q     <= '0;
         hold_q    <= '0;
         turn_q    <= '0;
         timeout_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         turn_q    <= turn_d;
         timeout_q <= timeout_d;
         busy_q    <= |gnt_d;
      end
   end

   assign gnt      = gnt_q;
   assign drv_en   = gnt_q;
   assign grant_id = owner_q;
   assign bus_busy = busy_q;
   assign timeout  = timeout_q;

`ifdef SNA_CONTENTION_CHECK_EN
   logic bus_err_q;

   // The first owned cycle is skipped: the new driver's enable is only just settling on the net.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_err_q <= 1'b0;
      end else if (state_q == S_OWN && hold_q >= HW'(2) && ((^bus_mon) === 1'bx)) begin
         bus_err_q <= 1'b1;
      end
   end

   assign bus_err = bus_err_q;
`else
   // DW only sizes bus_mon; referenced here so the default build still elaborates it.
   if (DW < 1) begin : g_dw_invalid
   end
`endif

endmodule
